bcd_scan_controller: RTL and testbench
======================================

# bcd_scan_controller

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display sharing a single BCD-to-7-segment decoder. Holds a frame of BCD digits and decimal points, then presents one digit at a time to the shared decoder. Drives the active-low digit enables and decimal point, with a dark blanking gap between digits to suppress ghosting. Sits between the numeric datapath (counters, clocks) and the board-level decoder/display pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (2..8)
- SCAN_DIV, 50000, clk cycles per digit slot (blank + show)
- BLANK_CYCLES, 500, all-digits-off cycles at start of each slot; 1 <= BLANK_CYCLES < SCAN_DIV

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  scanning enabled; low forces display dark
- load  in  1  one-cycle strobe; capture bcd_in/dp_in into pending frame
- bcd_in  in  4*NUM_DIGITS  digit k at [4k+3:4k]; digit 0 = rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
- bcd_out  out  4  BCD code to shared decoder input
- digit_n  out  NUM_DIGITS  digit enables, active-low, at most one low
- dp_n  out  1  decimal point, active-low, for currently shown digit
- frame_done  out  1  one-cycle pulse at end of each complete frame

## Operation
- Registers: pending frame (bcd+dp), active frame (bcd+dp), state, digit index idx, slot counter cnt (width $clog2(SCAN_DIV)).
- load=1 captures bcd_in/dp_in into pending. Active frame is updated from pending only at frame boundary (entry to BLANK with idx=0), so one frame never mixes old and new digits.
- load coincident with a boundary: active takes bcd_in/dp_in directly (same-cycle bypass); pending also updated.
- States:
  - IDLE: digit_n all 1, dp_n=1, cnt=0, idx=0. enable=1 -> BLANK (frame boundary, idx=0).
  - BLANK: digit_n all 1, dp_n=1, bcd_out = active digit idx. cnt counts 0..BLANK_CYCLES-1 -> SHOW.
  - SHOW: digit_n[idx]=0 (unless suppressed), dp_n = ~dp[idx], bcd_out = active digit idx. cnt continues to SCAN_DIV-1, then cnt=0, idx advances -> BLANK; idx wraps NUM_DIGITS-1 -> 0 (frame boundary).
- enable=0 in any state -> IDLE next cycle; re-enable always restarts at idx=0 BLANK.
- bcd_out passes codes 10..15 unchanged; the decoder renders them as a dash.
- frame_done=1 for the single cycle of SHOW with idx=NUM_DIGITS-1 and cnt=SCAN_DIV-1.

## Timing
- Reset (rst=1 at a clk edge): state IDLE, idx=0, cnt=0, pending/active frames 0, bcd_out=0, digit_n all 1, dp_n=1, frame_done=0. Reset has priority over load and enable.
- All outputs registered; change on clk edge only.
- Slot length exactly SCAN_DIV cycles: BLANK_CYCLES dark, then SCAN_DIV-BLANK_CYCLES lit. Frame = NUM_DIGITS*SCAN_DIV cycles.
- bcd_out settles at BLANK entry, at least BLANK_CYCLES before digit enable, giving the decoder a full blank window.
- Load-to-display latency: value appears in the first slot after the next frame boundary (worst case NUM_DIGITS*SCAN_DIV+BLANK_CYCLES cycles).
- First lit digit after enable rises: BLANK_CYCLES+1 cycles later.

## Configuration
- LEADING_ZERO_BLANK_EN defined: from the most significant digit downward, each digit whose code is 0 while all higher digits are also 0 is suppressed (digit_n stays all 1 and dp_n=1 in its SHOW phase; timing unchanged). Digit 0 is never suppressed. Codes 10..15 count as nonzero. Suppression evaluated on the active frame.
- Not defined: every digit is shown in its SHOW phase regardless of value.

## Test plan
(NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 unless noted)
- Reset, enable=1, no load -> digit_n sequence 1110,1101,1011,0111 each low 6 cycles after 2 dark; bcd_out=0; frame_done every 32 cycles.
- load bcd_in=16'h1234, dp_in=4'b0100 -> next frame bcd_out 4,3,2,1 on idx 0..3; dp_n=0 only while digit_n=1011.
- load 16'h5678 mid-frame -> current frame completes with old digits; 16'h5678 begins at idx 0 after frame_done; load at exact boundary shows new value immediately.
- enable dropped during SHOW idx=2 -> next cycle digit_n=1111, dp_n=1; re-enable -> 2 dark cycles then digit_n=1110.
- bcd_in=16'h00A5 -> bcd_out 5,10,0,0; with LEADING_ZERO_BLANK_EN idx 2,3 stay dark, idx 1 shown; bcd_in=0 -> only digit 0 lit.
- rst asserted mid-SHOW with load=1 -> next cycle all outputs at reset values, frames cleared to 0.

Source files
------------

// File: rtl/bcd_scan_controller.sv
// bcd_scan_controller
// Time-multiplexed scan of a common-anode 7-segment display through one shared
// BCD decoder. A pending frame is captured on load and is promoted to the active
// frame only at a frame boundary, so a frame never mixes old and new digits.
// Every output is registered. The register inputs are computed from the
// next-state values, so outputs line up with the state they describe.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
//
// state | meaning
// IDLE  | scanning off, all digits dark, idx=0, cnt=0
// BLANK | digit idx selected on bcd_out, all enables off (anti-ghosting gap)
// SHOW  | digit idx enabled (unless suppressed), dp driven for that digit
module bcd_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d, act_bcd_q, act_bcd_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   suppress;

  logic [3:0]              bcd_out_d;
  logic [NUM_DIGITS-1:0]   digit_n_d;
  logic                    dp_n_d;
  logic                    frame_done_d;

  // State, frame and output registers; reset overrides load and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend_bcd_q <= '0;
      pend_dp_q  <= '0;
      act_bcd_q  <= '0;
      act_dp_q   <= '0;
      bcd_out    <= 4'd0;
      digit_n    <= '1;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pend_bcd_q <= pend_bcd_d;
      pend_dp_q  <= pend_dp_d;
      act_bcd_q  <= act_bcd_d;
      act_dp_q   <= act_dp_d;
      bcd_out    <= bcd_out_d;
      digit_n    <= digit_n_d;
      dp_n       <= dp_n_d;
      frame_done <= frame_done_d;
    end
  end

  // Next state, slot counter, digit index and frame promotion at boundaries.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    boundary   = 1'b0;
    pend_bcd_d = load ? bcd_in : pend_bcd_q;
    pend_dp_d  = load ? dp_in : pend_dp_q;
    act_bcd_d  = act_bcd_q;
    act_dp_d   = act_dp_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = BLANK;
          idx_d    = '0;
          cnt_d    = '0;
          boundary = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) state_d = SHOW;
          cnt_d = cnt_q + CW'(1);
        end
        SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
    // pend_*_d already carries a same-cycle load, giving the boundary bypass.
    if (boundary) begin
      act_bcd_d = pend_bcd_d;
      act_dp_d  = pend_dp_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is suppressed when it and every higher digit are zero; digit 0 never.
  always_comb begin
    logic zero_above;
    suppress   = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above && (act_bcd_d[4*k +: 4] == 4'd0);
      suppress[k] = zero_above;
    end
  end
`else
  assign suppress = '0;
`endif

  // Output values for the upcoming cycle, decoded from next-state values.
  always_comb begin
    bcd_out_d    = 4'd0;
    digit_n_d    = '1;
    dp_n_d       = 1'b1;
    frame_done_d = (state_d == SHOW) && (idx_d == IDX_LAST) && (cnt_d == SLOT_LAST);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        bcd_out_d = act_bcd_d[4*k +: 4];
        if ((state_d == SHOW) && !suppress[k]) begin
          digit_n_d[k] = 1'b0;
          dp_n_d       = ~act_dp_d[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_controller.sv
// Bench for bcd_scan_controller (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2).
// The reference model tracks a position inside the frame and derives the slot,
// the blank/lit phase and frame_done from it arithmetically.
module tb_bcd_scan_controller;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst, enable, load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_n;
  logic        dp_n, frame_done;

  int n_cmp = 0;
  int n_err = 0;

  bit          m_run, m_rst;
  int          m_p;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pdp, m_adp;

  always #5 clk = ~clk;

  bcd_scan_controller #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .bcd_in(bcd_in), .dp_in(dp_in),
    .bcd_out(bcd_out), .digit_n(digit_n), .dp_n(dp_n), .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (pos %0d)", tag, obs, exp, m_p);
    end
  endtask

  function automatic bit suppressed(input int slot);
`ifdef LEADING_ZERO_BLANK_EN
    return (slot > 0) && ((m_act >> (4 * slot)) == 16'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] rand_frame();
    logic [15:0] v;
    int nz;
    v = '0;
    for (int k = 0; k < ND; k++)
      v[4*k +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
    nz = $urandom_range(0, ND);
    for (int k = ND - nz; k < ND; k++) v[4*k +: 4] = 4'd0;
    return v;
  endfunction

  task automatic model_step();
    m_rst = rst;
    if (rst) begin
      m_run = 0; m_p = 0;
      m_pend = '0; m_pdp = '0; m_act = '0; m_adp = '0;
    end else begin
      if (load) begin m_pend = bcd_in; m_pdp = dp_in; end
      if (!enable) m_run = 0;
      else begin
        if (!m_run) begin m_run = 1; m_p = 0; end
        else m_p = (m_p + 1) % FRAME;
        if (m_p == 0) begin m_act = m_pend; m_adp = m_pdp; end
      end
    end
  endtask

  task automatic check_outputs();
    int slot, off;
    bit lit;
    logic [3:0] e_dn, e_bcd;
    logic e_dp, e_fd;
    slot  = m_run ? m_p / SD : 0;
    off   = m_p % SD;
    e_bcd = m_act[4*slot +: 4];
    lit   = m_run && (off >= BC) && !suppressed(slot);
    e_dn  = lit ? ~(4'b0001 << slot) : 4'b1111;
    e_dp  = lit ? ~m_adp[slot] : 1'b1;
    e_fd  = m_run && (m_p == FRAME - 1);
    check("digit_n", 16'(digit_n), 16'(e_dn));
    check("dp_n", 16'(dp_n), 16'(e_dp));
    check("frame_done", 16'(frame_done), 16'(e_fd));
    if (m_run || m_rst) check("bcd_out", 16'(bcd_out), 16'(e_bcd));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_pos(input int target, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (m_run && m_p == target) hit = 1;
      else tick();
    end
    if (m_run && m_p == target) hit = 1;
    n_cmp++;
    assert (hit) else begin
      n_err++;
      $error("FAIL wait_pos observed=timeout expected=pos %0d", target);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0;
    m_run = 0; m_rst = 0; m_p = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    // Free-running scan of an all-zero frame.
    enable = 1'b1;
    run(FRAME + 4);
    // Mid-frame load: shows only from the next boundary.
    wait_pos(10, 40);
    load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0100;
    tick();
    load = 1'b0; bcd_in = 16'($urandom); dp_in = 4'($urandom);
    run(2 * FRAME);
    wait_pos(13, 40);
    load = 1'b1; bcd_in = 16'h5678; dp_in = 4'($urandom);
    tick();
    load = 1'b0;
    run(FRAME + 2);
    // Load coincident with the boundary edge: bypass into the active frame.
    wait_pos(FRAME - 1, 40);
    load = 1'b1; bcd_in = rand_frame(); dp_in = 4'($urandom);
    tick();
    load = 1'b0;
    run(FRAME);
    // Drop enable while digit 2 is lit, then restart.
    wait_pos(2 * SD + BC + $urandom_range(0, SD - BC - 1), 40);
    enable = 1'b0;
    run(3);
    enable = 1'b1;
    run(FRAME);
    // Codes above 9 and leading zeros.
    load = 1'b1; bcd_in = 16'h00A5; dp_in = 4'($urandom);
    tick();
    load = 1'b0;
    run(2 * FRAME);
    load = 1'b1; bcd_in = 16'h0000; dp_in = 4'($urandom);
    tick();
    load = 1'b0;
    run(2 * FRAME);
    // Randomized loads and enable drops.
    for (int i = 0; i < 400; i++) begin
      load   = ($urandom_range(0, 9) == 0);
      enable = ($urandom_range(0, 49) != 0);
      bcd_in = rand_frame();
      dp_in  = 4'($urandom);
      tick();
    end
    load = 1'b0; enable = 1'b1;
    run(FRAME);
    // Reset during SHOW with a coincident load.
    wait_pos(SD + 4, 40);
    rst = 1'b1; load = 1'b1; bcd_in = 16'h9876; dp_in = 4'hF;
    tick();
    rst = 1'b0; load = 1'b0;
    run(FRAME + 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
